and_array_bist: RTL

- Parametrised successor to the dual 4-input AND part in the 74LSXX library: CHANNELS independent INPUTS-wide AND gates with registered outputs.
- Adds an on-chip built-in self-test (BIST) sequencer. On request, it sweeps all 2^INPUTS patterns through every channel, checks each result against expected, and reports pass/fail per channel plus the first failing pattern.
- Used as a library primitive in lab designs and as a self-checking board-bring-up block.

---
 rtl/and_array_bist_pkg.sv | 11 +
 rtl/and_n_gate.sv | 17 +
 rtl/and_array_bist.sv | 125 ++++++++++++
 3 files changed

// File: rtl/and_array_bist_pkg.sv
// Shared types for the AND-array primitive and its self-test sequencer.
package and_array_bist_pkg;

  typedef enum logic [1:0] {
    BIST_IDLE  = 2'd0,
    BIST_RUN   = 2'd1,
    BIST_DRAIN = 2'd2,
    BIST_DONE  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/and_n_gate.sv
// Single INPUTS-wide AND gate, the leaf cell of the 74LSXX-style AND array.
module and_n_gate #(
  parameter int INPUTS = 4,
  parameter int DELAY  = 0
) (
  input  logic [INPUTS-1:0] a_i,
  output logic              y_o
);

  assign y_o = &a_i;

  // DELAY is only meaningful to timing-annotated simulation; here it is range-checked.
  if (DELAY < 0) begin : g_bad_delay
    $error("and_n_gate: DELAY must be non-negative");
  end

endmodule

// File: rtl/and_array_bist.sv
// CHANNELS independent registered AND gates with an exhaustive-pattern self-test.
module and_array_bist
  import and_array_bist_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int INPUTS   = 4,
  parameter int DELAY    = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [CHANNELS*INPUTS-1:0] A,
  output logic [CHANNELS-1:0]        Y,
  input  logic                       bist_start,
  input  logic [CHANNELS-1:0]        fault_inj,
  output logic                       bist_busy,
  output logic                       bist_done,
  output logic                       bist_pass,
  output logic [CHANNELS-1:0]        bist_fail_ch,
  output logic [INPUTS-1:0]          bist_err_pattern
);

  localparam logic [INPUTS:0] LastPat = (INPUTS+1)'((1 << INPUTS) - 1);

  bist_state_e           state_q, state_d;
  logic [INPUTS:0]       cnt_q, cnt_d;
  logic [INPUTS-1:0]     pat_dly_q, pat_dly_d;
  logic [CHANNELS-1:0]   res_q, res_d;
  logic                  cmp_q, cmp_d;
  logic [CHANNELS-1:0]   y_q, y_d;
  logic                  pass_q, pass_d;
  logic [CHANNELS-1:0]   fail_q, fail_d;
  logic [INPUTS-1:0]     err_q, err_d;

  logic [CHANNELS*INPUTS-1:0] gate_in;
  logic [CHANNELS-1:0]        gate_y;
  logic [CHANNELS-1:0]        gate_out;
  logic [CHANNELS-1:0]        mism;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign gate_in[c*INPUTS +: INPUTS] = (state_q == BIST_RUN) ? cnt_q[INPUTS-1:0]
                                                               : A[c*INPUTS +: INPUTS];
    and_n_gate #(
      .INPUTS (INPUTS),
      .DELAY  (DELAY)
    ) u_gate (
      .a_i (gate_in[c*INPUTS +: INPUTS]),
      .y_o (gate_y[c])
    );
  end

  assign gate_out = gate_y ^ fault_inj;
  // Result captured one cycle earlier is checked against "pattern was all-ones".
  assign mism     = cmp_q ? (res_q ^ {CHANNELS{&pat_dly_q}}) : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_dly_d = pat_dly_q;
    res_d     = res_q;
    cmp_d     = 1'b0;
    y_d       = y_q;
    pass_d    = pass_q;
    fail_d    = fail_q | mism;
    err_d     = ((|mism) && !(|fail_q)) ? pat_dly_q : err_q;
    case (state_q)
      BIST_IDLE: begin
        if (bist_start) begin
          state_d = BIST_RUN;
          cnt_d   = '0;
          fail_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end else begin
          y_d = gate_out;
        end
      end
      BIST_RUN: begin
        res_d     = gate_out;
        pat_dly_d = cnt_q[INPUTS-1:0];
        cmp_d     = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LastPat) state_d = BIST_DRAIN;
      end
      BIST_DRAIN: begin
        state_d = BIST_DONE;
        pass_d  = ~|fail_d;
      end
      BIST_DONE: begin
        state_d = BIST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= BIST_IDLE;
      cnt_q     <= '0;
      pat_dly_q <= '0;
      res_q     <= '0;
      cmp_q     <= 1'b0;
      y_q       <= '0;
      pass_q    <= 1'b0;
      fail_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_dly_q <= pat_dly_d;
      res_q     <= res_d;
      cmp_q     <= cmp_d;
      y_q       <= y_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
    end
  end

  assign Y                = y_q;
  assign bist_busy        = (state_q == BIST_RUN) || (state_q == BIST_DRAIN);
  assign bist_done        = (state_q == BIST_DONE);
  assign bist_pass        = pass_q;
  assign bist_fail_ch     = fail_q;
  assign bist_err_pattern = err_q;

endmodule
